z3_slave_engine: RTL and testbench

Parametrised Zorro III slave-cycle sequencer for the A4092 CPLD. It replaces the fixed four-state slave machine with a clock-synchronous engine on CLK_50M. Features: NUM_TGT one-hot target ports, synchronised bus inputs, a programmable DTACK delay, and a watchdog that turns a hung target into BERR. It sits between the address-latch/region decode and the per-region access blocks (ROM, SCSI, SID, SPI, interrupt, autoconfig).

---
 rtl/z3_pkg.sv | 27 ++
 rtl/z3_sync.sv | 26 ++
 rtl/z3_slave_engine.sv | 148 ++++++++++++++
 tb/tb_z3_slave_engine.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/z3_pkg.sv
// Shared Zorro III slave-cycle definitions: state encoding, defaults and grant
// priority encoder used by the slave engine and the existing region blocks.
package z3_pkg;

   typedef enum logic [2:0] {
      Z3_IDLE  = 3'd0,
      Z3_START = 3'd1,
      Z3_DATA  = 3'd2,
      Z3_HOLD  = 3'd3,
      Z3_ACK   = 3'd4,
      Z3_ERR   = 3'd5,
      Z3_DRAIN = 3'd6
   } z3_state_t;

   localparam int Z3_DTACK_DLY_DEF = 1;
   localparam int Z3_TIMEOUT_DEF   = 255;

   // Index of the lowest set bit; 0 when nothing is set, so callers must
   // qualify an all-zero input themselves.
   function automatic logic [3:0] lowest_one(input logic [15:0] v);
      lowest_one = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) lowest_one = 4'(i);
      end
   endfunction

endpackage

// File: rtl/z3_sync.sv
// N-bit multi-flop synchroniser for asynchronous Zorro strobes; resets to all
// ones so the strobes read as inactive while IORST_n is low.
module z3_sync #(
   parameter int W      = 1,
   parameter int STAGES = 2
) (
   input  logic         CLK_50M,
   input  logic         IORST_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_ff [STAGES];

   always_ff @(posedge CLK_50M or negedge IORST_n) begin
      if (!IORST_n) begin
         for (int i = 0; i < STAGES; i++) r_ff[i] <= '1;
      end else begin
         r_ff[0] <= i_d;
         for (int i = 1; i < STAGES; i++) r_ff[i] <= r_ff[i-1];
      end
   end

   assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/z3_slave_engine.sv
// Clock-synchronous Zorro III slave-cycle sequencer: grants one target region,
// paces DTACK after the target acks, and turns a hung target into BERR.
module z3_slave_engine
   import z3_pkg::*;
#(
   parameter int NUM_TGT     = 6,
   parameter int SYNC_STAGES = 2,
   parameter int DTACK_DLY   = Z3_DTACK_DLY_DEF,
   parameter int TIMEOUT     = Z3_TIMEOUT_DEF,
   parameter int BERR_EN     = 1
) (
   input  logic               CLK_50M,
   input  logic               IORST_n,
   input  logic               fcs_n,
   input  logic [3:0]         ds_n,
   input  logic               read,
   input  logic               addr_match,
   input  logic               validspace,
   input  logic [NUM_TGT-1:0] tgt_sel,
   input  logic [NUM_TGT-1:0] tgt_ack,
   output logic [NUM_TGT-1:0] tgt_req,
   output logic               cyc_read,
   output logic               dtack_oe,
   output logic               berr_oe,
   output logic               busy,
   output logic [15:0]        timeout_cnt,
   output logic [2:0]         dbg_state
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic               w_fcs_s;
   logic [3:0]         w_ds_s;
   logic [NUM_TGT-1:0] w_sel_gnt;
   logic               w_ack_hit;
   logic               w_wd_done;

   z3_state_t          r_state;
   logic [NUM_TGT-1:0] r_gnt;
   logic [NUM_TGT-1:0] r_req;
   logic [2:0]         r_dly;
   logic [WD_W-1:0]    r_wd;
   logic [15:0]        r_tcnt;
   logic               r_rd;
   logic               r_dtack;
   logic               r_berr;
   logic               r_busy;

   z3_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_fcs (
      .CLK_50M (CLK_50M),
      .IORST_n (IORST_n),
      .i_d     (fcs_n),
      .o_q     (w_fcs_s)
   );

   z3_sync #(.W(4), .STAGES(SYNC_STAGES)) u_sync_ds (
      .CLK_50M (CLK_50M),
      .IORST_n (IORST_n),
      .i_d     (ds_n),
      .o_q     (w_ds_s)
   );

   // Grant is kept one-hot so the ack match and the request need no indexing.
   assign w_sel_gnt = (tgt_sel == '0) ? '0
                    : NUM_TGT'(16'd1 << lowest_one(16'(tgt_sel)));
   assign w_ack_hit = |(tgt_ack & r_gnt);
   assign w_wd_done = (r_wd == WD_W'(TIMEOUT - 1));

   always_ff @(posedge CLK_50M or negedge IORST_n) begin
      if (!IORST_n) begin
         r_state <= Z3_IDLE;
         r_gnt   <= '0;
         r_req   <= '0;
         r_dly   <= '0;
         r_wd    <= '0;
         r_tcnt  <= '0;
         r_rd    <= 1'b0;
         r_dtack <= 1'b0;
         r_berr  <= 1'b0;
         r_busy  <= 1'b0;
      end else if (r_state != Z3_IDLE && w_fcs_s) begin
         // Bus master ended or aborted the cycle: release everything at once.
         r_state <= Z3_IDLE;
         r_req   <= '0;
         r_dtack <= 1'b0;
         r_berr  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            Z3_IDLE: begin
               if (!w_fcs_s && addr_match && validspace) begin
                  r_state <= Z3_START;
                  r_busy  <= 1'b1;
                  r_rd    <= read;
                  r_gnt   <= w_sel_gnt;
               end
            end
            Z3_START: begin
               if (r_gnt == '0) begin
                  r_state <= Z3_DRAIN;
               end else if (r_rd || w_ds_s != 4'hF) begin
                  r_state <= Z3_DATA;
                  r_req   <= r_gnt;
                  r_wd    <= '0;
               end
            end
            Z3_DATA: begin
               if (w_ack_hit) begin
                  if (DTACK_DLY == 0) begin
                     r_state <= Z3_ACK;
                     r_dtack <= 1'b1;
                  end else begin
                     r_state <= Z3_HOLD;
                     r_dly   <= 3'(DTACK_DLY);
                  end
               end else if (w_wd_done) begin
                  r_state <= Z3_ERR;
                  r_req   <= '0;
                  if (r_tcnt != 16'hFFFF) r_tcnt <= r_tcnt + 16'd1;
                  if (BERR_EN != 0) r_berr  <= 1'b1;
                  else              r_dtack <= 1'b1;
               end else begin
                  r_wd <= r_wd + 1'b1;
               end
            end
            Z3_HOLD: begin
               if (r_dly <= 3'd1) begin
                  r_state <= Z3_ACK;
                  r_dtack <= 1'b1;
               end else begin
                  r_dly <= r_dly - 3'd1;
               end
            end
            Z3_ACK, Z3_ERR, Z3_DRAIN: ;
            default: r_state <= Z3_IDLE;
         endcase
      end
   end

   assign tgt_req     = r_req;
   assign cyc_read    = r_rd;
   assign dtack_oe    = r_dtack;
   assign berr_oe     = r_berr;
   assign busy        = r_busy;
   assign timeout_cnt = r_tcnt;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_z3_slave_engine.sv
// Directed bench for z3_slave_engine; a forked monitor checks every DTACK/BERR
// assertion and every return to idle against an expected-event queue.
module tb_z3_slave_engine;
   import z3_pkg::*;

   localparam int NT = 6;

   logic          CLK_50M    = 1'b0;
   logic          IORST_n    = 1'b0;
   logic          fcs_n      = 1'b1;
   logic [3:0]    ds_n       = 4'hF;
   logic          read       = 1'b0;
   logic          addr_match = 1'b0;
   logic          validspace = 1'b0;
   logic [NT-1:0] tgt_sel    = '0;
   logic [NT-1:0] tgt_ack    = '0;

   logic [NT-1:0] tgt_req, tgt_req0;
   logic          cyc_read, cyc_read0, dtack_oe, dtack_oe0, berr_oe, berr_oe0;
   logic          busy, busy0;
   logic [15:0]   timeout_cnt, timeout_cnt0;
   logic [2:0]    dbg_state, dbg_state0;

   int            cyc = 0;
   int            ref_cyc = 0;
   int            total = 0;
   int            bad = 0;
   logic [15:0]   exp_tcnt = 16'd0;
   logic [32:0]   exp_q[$];

   z3_slave_engine #(.NUM_TGT(NT), .SYNC_STAGES(2), .DTACK_DLY(1), .TIMEOUT(20), .BERR_EN(1)) u_dut (
      .CLK_50M(CLK_50M), .IORST_n(IORST_n), .fcs_n(fcs_n), .ds_n(ds_n), .read(read),
      .addr_match(addr_match), .validspace(validspace), .tgt_sel(tgt_sel), .tgt_ack(tgt_ack),
      .tgt_req(tgt_req), .cyc_read(cyc_read), .dtack_oe(dtack_oe), .berr_oe(berr_oe),
      .busy(busy), .timeout_cnt(timeout_cnt), .dbg_state(dbg_state)
   );

   z3_slave_engine #(.NUM_TGT(NT), .SYNC_STAGES(2), .DTACK_DLY(1), .TIMEOUT(20), .BERR_EN(0)) u_dut0 (
      .CLK_50M(CLK_50M), .IORST_n(IORST_n), .fcs_n(fcs_n), .ds_n(ds_n), .read(read),
      .addr_match(addr_match), .validspace(validspace), .tgt_sel(tgt_sel), .tgt_ack(tgt_ack),
      .tgt_req(tgt_req0), .cyc_read(cyc_read0), .dtack_oe(dtack_oe0), .berr_oe(berr_oe0),
      .busy(busy0), .timeout_cnt(timeout_cnt0), .dbg_state(dbg_state0)
   );

   always #10 CLK_50M = ~CLK_50M;
   always @(posedge CLK_50M) cyc <= cyc + 1;

   // Event word: {kind, tgt_req, cyc_read, timeout_cnt, latency from ref_cyc}.
   // kind 1 = DTACK rise, 2 = BERR rise, 3 = busy fall.
   function automatic logic [32:0] pack(input logic [1:0] kind, input logic [5:0] req,
                                        input logic rd, input logic [15:0] tc, input logic [7:0] lat);
      pack = {kind, req, rd, tc, lat};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic sb_check(input logic [32:0] got);
      logic [32:0] exp;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL sb_unexpected got=%0h", got);
      end else begin
         exp = exp_q.pop_front();
         if (got !== exp) begin
            bad++;
            $display("FAIL sb_event got=%0h exp=%0h", got, exp);
         end
      end
   endtask

   task automatic monitor_loop();
      logic p_dt = 1'b0, p_be = 1'b0, p_bs = 1'b0;
      forever begin
         @(negedge CLK_50M);
         if (!IORST_n) begin
            p_dt = 1'b0; p_be = 1'b0; p_bs = 1'b0;
         end else begin
            if (dtack_oe && !p_dt) sb_check(pack(2'd1, tgt_req, cyc_read, timeout_cnt, 8'(cyc - ref_cyc)));
            if (berr_oe && !p_be)  sb_check(pack(2'd2, tgt_req, cyc_read, timeout_cnt, 8'(cyc - ref_cyc)));
            if (!busy && p_bs)     sb_check(pack(2'd3, tgt_req, 1'b0, timeout_cnt, 8'(cyc - ref_cyc)));
            if (dtack_oe && berr_oe) begin
               bad++;
               $display("FAIL oe_exclusive dtack=%0b berr=%0b", dtack_oe, berr_oe);
            end
            p_dt = dtack_oe; p_be = berr_oe; p_bs = busy;
         end
      end
   endtask

   task automatic tick();
      @(posedge CLK_50M); #1;
   endtask

   task automatic start_cyc(input logic [5:0] sel, input logic rd, input logic [3:0] ds);
      tick();
      tgt_sel = sel; read = rd; ds_n = ds; addr_match = 1'b1; validspace = 1'b1; fcs_n = 1'b0;
   endtask

   task automatic wait_req(input logic [5:0] exp, input string name);
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK_50M);
         if (tgt_req != '0) break;
      end
      ref_cyc = cyc;
      chk(name, 32'(tgt_req), 32'(exp));
   endtask

   task automatic ack_push(input logic [5:0] ack, input logic [5:0] exp_req, input logic rd);
      tick();
      tgt_ack = ack;
      ref_cyc = cyc;
      exp_q.push_back(pack(2'd1, exp_req, rd, exp_tcnt, 8'd2));
   endtask

   task automatic wait_out(input logic want_berr);
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK_50M);
         if (want_berr ? berr_oe : dtack_oe) break;
      end
   endtask

   task automatic end_cyc();
      tick();
      fcs_n = 1'b1; ds_n = 4'hF; tgt_ack = '0; addr_match = 1'b0; validspace = 1'b0;
      ref_cyc = cyc;
      exp_q.push_back(pack(2'd3, 6'd0, 1'b0, exp_tcnt, 8'd3));
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK_50M);
         if (!busy) break;
      end
      repeat (2) tick();
   endtask

   initial begin
      fork
         monitor_loop();
      join_none

      repeat (3) @(posedge CLK_50M);
      #1;
      chk("rst_dtack", 32'(dtack_oe), 32'd0);
      chk("rst_berr", 32'(berr_oe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req", 32'(tgt_req), 32'd0);
      chk("rst_tcnt", 32'(timeout_cnt), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(Z3_IDLE));
      IORST_n = 1'b1;
      repeat (3) tick();

      // Read cycle, target 2, ack five cycles after the request
      start_cyc(6'b000100, 1'b1, 4'hF);
      wait_req(6'b000100, "t1_req");
      repeat (4) tick();
      ack_push(6'b000100, 6'b000100, 1'b1);
      wait_out(1'b0);
      end_cyc();

      // Write cycle: START must wait for a data strobe
      start_cyc(6'b000001, 1'b0, 4'hF);
      repeat (6) tick();
      @(negedge CLK_50M);
      chk("t2_start_hold", 32'(dbg_state), 32'(Z3_START));
      chk("t2_no_req", 32'(tgt_req), 32'd0);
      tick();
      ds_n = 4'b1100;
      wait_req(6'b000001, "t2_req");
      chk("t2_cyc_read", 32'(cyc_read), 32'd0);
      ack_push(6'b000001, 6'b000001, 1'b0);
      wait_out(1'b0);
      end_cyc();

      // Multi-hot select: lowest index granted, other acks and sel changes ignored
      start_cyc(6'b100110, 1'b1, 4'hF);
      wait_req(6'b000010, "t5_req");
      tick();
      tgt_sel = 6'b000001;
      tgt_ack = 6'b000100;
      repeat (5) tick();
      @(negedge CLK_50M);
      chk("t5_still_data", 32'(dbg_state), 32'(Z3_DATA));
      chk("t5_no_dtack", 32'(dtack_oe), 32'd0);
      chk("t5_req_frozen", 32'(tgt_req), 32'b000010);
      ack_push(6'b000110, 6'b000010, 1'b1);
      wait_out(1'b0);
      end_cyc();

      // No ack: watchdog fires 20 cycles after DATA entry
      start_cyc(6'b000010, 1'b1, 4'hF);
      wait_req(6'b000010, "t3_req");
      exp_tcnt = 16'd1;
      exp_q.push_back(pack(2'd2, 6'd0, 1'b1, 16'd1, 8'd20));
      wait_out(1'b1);
      chk("t3_no_dtack", 32'(dtack_oe), 32'd0);
      chk("t4_dtack_forced", 32'(dtack_oe0), 32'd1);
      chk("t4_no_berr", 32'(berr_oe0), 32'd0);
      chk("t4_tcnt", 32'(timeout_cnt0), 32'd1);
      end_cyc();

      // Unclaimed access drains with no DTACK or BERR
      start_cyc(6'b000000, 1'b1, 4'hF);
      repeat (8) tick();
      @(negedge CLK_50M);
      chk("drain_state", 32'(dbg_state), 32'(Z3_DRAIN));
      chk("drain_req", 32'(tgt_req), 32'd0);
      chk("drain_oe", 32'({dtack_oe, berr_oe}), 32'd0);
      end_cyc();

      // Abort in DATA, then a normal cycle
      start_cyc(6'b001000, 1'b1, 4'hF);
      wait_req(6'b001000, "ab_req");
      repeat (3) tick();
      end_cyc();
      start_cyc(6'b001000, 1'b1, 4'hF);
      wait_req(6'b001000, "ab_next_req");
      ack_push(6'b001000, 6'b001000, 1'b1);
      wait_out(1'b0);
      end_cyc();

      // Reset asserted while DTACK is driven
      start_cyc(6'b010000, 1'b1, 4'hF);
      wait_req(6'b010000, "rs_req");
      ack_push(6'b010000, 6'b010000, 1'b1);
      wait_out(1'b0);
      #3;
      IORST_n = 1'b0;
      #1;
      chk("rs_dtack", 32'(dtack_oe), 32'd0);
      chk("rs_req_drop", 32'(tgt_req), 32'd0);
      chk("rs_busy", 32'(busy), 32'd0);
      chk("rs_tcnt", 32'(timeout_cnt), 32'd0);
      chk("rs_dtack0", 32'(dtack_oe0), 32'd0);
      exp_tcnt = 16'd0;
      fcs_n = 1'b1; tgt_ack = '0; addr_match = 1'b0; validspace = 1'b0;
      repeat (2) tick();
      IORST_n = 1'b1;
      repeat (4) tick();
      start_cyc(6'b100000, 1'b1, 4'hF);
      wait_req(6'b100000, "rs_next_req");
      ack_push(6'b100000, 6'b100000, 1'b1);
      wait_out(1'b0);
      end_cyc();

      repeat (3) tick();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
